// File: rtl/apb_spi_pkg.sv
// rtl/apb_spi_pkg.sv - shared constants and types for the APB SPI front-end
//
// Contents:
//   OFS_*              byte offsets of the four SPI registers inside the 64-byte window
//   REG_IDX_*          strobe bit positions (o_WRn / o_DRn index)
//   SYNC_MASK_DEFAULT  default RF sync pattern mask (bit 0 = newest sample)
//   sck_div_e          SCK divider codes held in CONFIG[1:0]
//   spi_config_t       CONFIG register field layout
//   sck_div_ratio()    PCLK-to-SCK division ratio for a divider code

package apb_spi_pkg;

    localparam logic [5:0] OFS_CONFIG = 6'h00;
    localparam logic [5:0] OFS_STATUS = 6'h00;
    localparam logic [5:0] OFS_TX     = 6'h04;
    localparam logic [5:0] OFS_RX     = 6'h04;
    localparam logic [5:0] OFS_REG2   = 6'h08;
    localparam logic [5:0] OFS_CMD    = 6'h0C;

    localparam int NUM_REGS   = 4;
    localparam int REG_IDX_0  = 0;
    localparam int REG_IDX_1  = 1;
    localparam int REG_IDX_2  = 2;
    localparam int REG_IDX_3  = 3;

    localparam logic [63:0] SYNC_MASK_DEFAULT = 64'h3E00_000F_8000_00FF;

    typedef enum logic [1:0] {
        SCK_DIV2  = 2'b00,
        SCK_DIV4  = 2'b01,
        SCK_DIV8  = 2'b10,
        SCK_DIV16 = 2'b11
    } sck_div_e;

    typedef struct packed {
        logic [1:0] rsvd;
        logic [1:0] mode;
        logic [1:0] slave;
        sck_div_e   sck;
    } spi_config_t;

    function automatic int sck_div_ratio(input sck_div_e code);
        return 2 << int'(code);
    endfunction

endpackage

// File: rtl/apb_sync_detect.sv
// rtl/apb_sync_detect.sv - RF sync-word detector with sticky packet flag
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   rfin       in   RF pulse; a pulse anywhere in a bit period marks a 1
//   sh_en      in   one-cycle bit-period tick; shifts the latched sample in
//   status_rd  in   STATUS read strobe; clears pkt_rec
//   pkt_rec    out  sticky sync-received flag

module apb_sync_detect
    import apb_spi_pkg::*;
#(
    parameter int                SYNC_W    = 64,
    parameter logic [SYNC_W-1:0] SYNC_MASK = SYNC_W'(SYNC_MASK_DEFAULT)
) (
    input  logic clk,
    input  logic rst,
    input  logic rfin,
    input  logic sh_en,
    input  logic status_rd,
    output logic pkt_rec
);

    logic              lat;
    logic [SYNC_W-1:0] sr;
    logic              match;

    always_comb begin
        match = ((sr & SYNC_MASK) == SYNC_MASK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= '0;
            lat     <= 1'b0;
            pkt_rec <= 1'b0;
        end else begin
            // A match empties the register so the same word cannot re-trigger;
            // any sample arriving on that cycle is deliberately discarded.
            if (match) begin
                sr <= '0;
            end else if (sh_en) begin
                sr <= {sr[SYNC_W-2:0], lat | rfin};
            end

            // The latch spans one bit period; a pulse on the tick itself is
            // consumed directly by the shift above.
            if (sh_en) begin
                lat <= 1'b0;
            end else if (rfin) begin
                lat <= 1'b1;
            end

            // Set beats clear so a detection is never lost to a coincident read.
            if (match) begin
                pkt_rec <= 1'b1;
            end else if (status_rd) begin
                pkt_rec <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/apb_spi_bridge.sv
// rtl/apb_spi_bridge.sv - APB slave front-end for the SPI master register file
//
// Ports:
//   i_PCLK, i_PRESET             clock, synchronous active-high reset
//   i_PSEL0, i_PENABLE, i_PWRITE APB control
//   i_PADDR[15:0], i_PWDATA[7:0] APB address / write data
//   i_PRDATA[7:0]                read data from the register file
//   i_BASE_ADDR[9:0]             window base, compared with i_PADDR[15:6]
//   o_WR0..3                     write strobes: CONFIG, TX, reg2, CMD
//   o_DR0..3                     read strobes: STATUS, RX, reg2, reg3
//   PREADY                       APB ready (zero wait states)
//   o_PWDATA[7:0]                write data to the register file
//   o_PRDATA[7:0]                read data to the APB master
//   rfin, sh_en                  RF pulse input and bit-period tick
//   pkt_rec                      sticky sync-word-received flag

module apb_spi_bridge
    import apb_spi_pkg::*;
#(
    parameter int                SYNC_W    = 64,
    parameter logic [SYNC_W-1:0] SYNC_MASK = SYNC_W'(SYNC_MASK_DEFAULT)
) (
    input  logic       i_PCLK,
    input  logic       i_PRESET,
    input  logic       i_PSEL0,
    input  logic       i_PENABLE,
    input  logic       i_PWRITE,
    input  logic [15:0] i_PADDR,
    input  logic [7:0] i_PWDATA,
    input  logic [7:0] i_PRDATA,
    input  logic [9:0] i_BASE_ADDR,
    output logic       o_WR0,
    output logic       o_WR1,
    output logic       o_WR2,
    output logic       o_WR3,
    output logic       o_DR0,
    output logic       o_DR1,
    output logic       o_DR2,
    output logic       o_DR3,
    output logic       PREADY,
    output logic [7:0] o_PWDATA,
    output logic [7:0] o_PRDATA,
    input  logic       rfin,
    input  logic       sh_en,
    output logic       pkt_rec
);

    logic                access;
    logic                base_hit;
    logic [5:0]          ofs;
    logic [NUM_REGS-1:0] reg_sel;
    logic [NUM_REGS-1:0] wr_str;
    logic [NUM_REGS-1:0] rd_str;

    always_comb begin
        // Reset gates the access so every combinational output is low
        // while reset is held, including an aborted access phase.
        access   = i_PSEL0 & i_PENABLE & ~i_PRESET;
        base_hit = (i_PADDR[15:6] == i_BASE_ADDR);
        ofs      = i_PADDR[5:0];

        // Exact offset compare also rejects misaligned addresses and
        // offsets beyond the last register.
        reg_sel = '0;
        if (base_hit) begin
            reg_sel[REG_IDX_0] = (ofs == OFS_CONFIG);
            reg_sel[REG_IDX_1] = (ofs == OFS_TX);
            reg_sel[REG_IDX_2] = (ofs == OFS_REG2);
            reg_sel[REG_IDX_3] = (ofs == OFS_CMD);
        end

        wr_str = (access &  i_PWRITE) ? reg_sel : '0;
        rd_str = (access & ~i_PWRITE) ? reg_sel : '0;
    end

    assign o_WR0 = wr_str[REG_IDX_0];
    assign o_WR1 = wr_str[REG_IDX_1];
    assign o_WR2 = wr_str[REG_IDX_2];
    assign o_WR3 = wr_str[REG_IDX_3];
    assign o_DR0 = rd_str[REG_IDX_0];
    assign o_DR1 = rd_str[REG_IDX_1];
    assign o_DR2 = rd_str[REG_IDX_2];
    assign o_DR3 = rd_str[REG_IDX_3];

    // Every access completes, decoded or not, so a stray address cannot hang the bus.
    assign PREADY   = access;
    assign o_PWDATA = (access & i_PWRITE) ? i_PWDATA : 8'h00;
    assign o_PRDATA = (|rd_str) ? i_PRDATA : 8'h00;

    apb_sync_detect #(
        .SYNC_W    (SYNC_W),
        .SYNC_MASK (SYNC_MASK)
    ) u_sync (
        .clk       (i_PCLK),
        .rst       (i_PRESET),
        .rfin      (rfin),
        .sh_en     (sh_en),
        .status_rd (rd_str[REG_IDX_0]),
        .pkt_rec   (pkt_rec)
    );

endmodule

// File: tb/tb_apb_spi_bridge.sv
// tb/tb_apb_spi_bridge.sv - self-checking bench for apb_spi_bridge

module tb_apb_spi_bridge;

    localparam logic [63:0] MASK = 64'h3E00_000F_8000_00FF;
    localparam logic [9:0]  BASE = 10'h001;

    logic        clk = 1'b0;
    logic        i_PRESET = 1'b1;
    logic        i_PSEL0 = 1'b0;
    logic        i_PENABLE = 1'b0;
    logic        i_PWRITE = 1'b0;
    logic [15:0] i_PADDR = 16'h0000;
    logic [7:0]  i_PWDATA = 8'h00;
    logic [7:0]  i_PRDATA = 8'h00;
    logic [9:0]  i_BASE_ADDR = BASE;
    logic        rfin = 1'b0;
    logic        sh_en = 1'b0;
    logic        o_WR0, o_WR1, o_WR2, o_WR3;
    logic        o_DR0, o_DR1, o_DR2, o_DR3;
    logic        PREADY;
    logic [7:0]  o_PWDATA, o_PRDATA;
    logic        pkt_rec;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_on = 0;
    bit rf_rand = 0;

    bit hist[$];
    bit lat_m = 0;
    bit pkt_m = 0;
    bit pat[72];

    always #5 clk = ~clk;

    apb_spi_bridge dut (
        .i_PCLK      (clk),
        .i_PRESET    (i_PRESET),
        .i_PSEL0     (i_PSEL0),
        .i_PENABLE   (i_PENABLE),
        .i_PWRITE    (i_PWRITE),
        .i_PADDR     (i_PADDR),
        .i_PWDATA    (i_PWDATA),
        .i_PRDATA    (i_PRDATA),
        .i_BASE_ADDR (i_BASE_ADDR),
        .o_WR0       (o_WR0),
        .o_WR1       (o_WR1),
        .o_WR2       (o_WR2),
        .o_WR3       (o_WR3),
        .o_DR0       (o_DR0),
        .o_DR1       (o_DR1),
        .o_DR2       (o_DR2),
        .o_DR3       (o_DR3),
        .PREADY      (PREADY),
        .o_PWDATA    (o_PWDATA),
        .o_PRDATA    (o_PRDATA),
        .rfin        (rfin),
        .sh_en       (sh_en),
        .pkt_rec     (pkt_rec)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Sync match on the sample history: every masked position, counted back
    // from the newest sample, must hold a 1.
    function automatic bit model_match();
        for (int i = 0; i < 64; i++) begin
            if (MASK[i]) begin
                if (i >= hist.size()) return 0;
                if (!hist[hist.size() - 1 - i]) return 0;
            end
        end
        return 1;
    endfunction

    function automatic logic [63:0] model_sr();
        logic [63:0] v = '0;
        for (int i = 0; i < 64; i++)
            if (i < hist.size()) v[i] = hist[hist.size() - 1 - i];
        return v;
    endfunction

    // Register number addressed, or -1 when nothing is decoded.
    function automatic int exp_reg(input logic [15:0] a);
        int ia = int'(a);
        if ((ia / 64) != int'(BASE)) return -1;
        if ((ia % 4) != 0) return -1;
        if (((ia % 64) / 4) >= 4) return -1;
        return (ia % 64) / 4;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            bit acc;
            int r;
            logic [3:0] e_wr, e_dr;
            acc  = i_PSEL0 && i_PENABLE && !i_PRESET;
            r    = exp_reg(i_PADDR);
            e_wr = (acc && i_PWRITE && r >= 0) ? (4'b0001 << r) : 4'b0000;
            e_dr = (acc && !i_PWRITE && r >= 0) ? (4'b0001 << r) : 4'b0000;
            check("strobes", {o_WR3, o_WR2, o_WR1, o_WR0, o_DR3, o_DR2, o_DR1, o_DR0}, {e_wr, e_dr});
            check("pready", PREADY, acc);
            check("pwdata", o_PWDATA, (acc && i_PWRITE) ? i_PWDATA : 8'h00);
            check("prdata", o_PRDATA, (e_dr != 0) ? i_PRDATA : 8'h00);
            check("pkt_rec", pkt_rec, pkt_m);
            check("sync_sr", dut.u_sync.sr, model_sr());
            if (i_PRESET) begin
                hist.delete();
                lat_m = 0;
                pkt_m = 0;
            end else begin
                if (model_match()) begin
                    hist.delete();
                    pkt_m = 1;
                end else begin
                    if (e_dr[0]) pkt_m = 0;
                    if (sh_en) begin
                        hist.push_back(lat_m | rfin);
                        if (hist.size() > 64) void'(hist.pop_front());
                    end
                end
                if (sh_en) lat_m = 0;
                else if (rfin) lat_m = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rf_rand) begin
            rfin  = ($urandom_range(0, 3) == 0);
            sh_en = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic do_reset();
        step();
        i_PRESET = 1'b1;
        step();
        i_PRESET = 1'b0;
    endtask

    // Leaves the bench inside the access cycle, after the falling edge.
    task automatic begin_xfer(input bit wr, input logic [15:0] a, input logic [7:0] d, input logic [7:0] rd);
        step();
        i_PSEL0   = 1'b1;
        i_PENABLE = 1'b0;
        i_PWRITE  = wr;
        i_PADDR   = a;
        i_PWDATA  = d;
        i_PRDATA  = rd;
        step();
        i_PENABLE = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_xfer();
        step();
        i_PSEL0   = 1'b0;
        i_PENABLE = 1'b0;
        i_PADDR   = 16'($urandom);
        i_PWDATA  = 8'($urandom);
        i_PRDATA  = 8'($urandom);
    endtask

    task automatic send_bits(input int n);
        step();
        for (int k = 0; k < n; k++) begin
            rfin = pat[k];
            step();
            rfin = 1'b0;
            step();
            step();
            sh_en = 1'b1;
            step();
            sh_en = 1'b0;
        end
    endtask

    function automatic logic [15:0] rand_addr();
        int         k   = $urandom_range(0, 7);
        logic [9:0] b   = BASE;
        logic [3:0] idx = 4'($urandom_range(0, 5));
        logic [1:0] lo  = 2'b00;
        if (k == 5) b = BASE ^ (10'h001 << $urandom_range(0, 9));
        if (k == 6) lo = 2'($urandom_range(1, 3));
        if (k == 7) return 16'($urandom);
        return {b, idx, lo};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int p = 0;
        int runs[6] = '{10, 5, 21, 5, 23, 8};
        for (int s = 0; s < 6; s++)
            for (int j = 0; j < runs[s]; j++) begin
                pat[p] = (s % 2 == 1);
                p++;
            end

        step();
        chk_on = 1;
        step();
        i_PRESET = 1'b0;
        @(negedge clk);
        check("rst_pkt", pkt_rec, 0);
        check("rst_sr", dut.u_sync.sr, 0);

        begin_xfer(1, 16'h0040, 8'h01, 8'h00);
        check("wr0_strobe", o_WR0, 1);
        check("wr0_data", o_PWDATA, 8'h01);
        check("wr0_ready", PREADY, 1);
        check("wr0_others", {o_WR1, o_WR2, o_WR3, o_DR0, o_DR1, o_DR2, o_DR3}, 0);
        end_xfer();
        @(negedge clk);
        check("idle_ready", PREADY, 0);
        check("idle_wr0", o_WR0, 0);

        begin_xfer(1, 16'h0044, 8'h55, 8'h00);
        check("wr1_strobe", o_WR1, 1);
        check("wr1_data", o_PWDATA, 8'h55);
        end_xfer();
        begin_xfer(1, 16'h004C, 8'h02, 8'h00);
        check("wr3_strobe", o_WR3, 1);
        check("wr3_data", o_PWDATA, 8'h02);
        end_xfer();
        begin_xfer(0, 16'h0044, 8'h00, 8'hA5);
        check("rd1_strobe", o_DR1, 1);
        check("rd1_data", o_PRDATA, 8'hA5);
        end_xfer();
        begin_xfer(0, 16'h0040, 8'h00, 8'h3C);
        check("rd0_strobe", o_DR0, 1);
        end_xfer();
        begin_xfer(1, 16'h0080, 8'h77, 8'h00);
        check("miss_strobes", {o_WR0, o_WR1, o_WR2, o_WR3}, 0);
        check("miss_ready", PREADY, 1);
        end_xfer();
        begin_xfer(0, 16'h0041, 8'h00, 8'hEE);
        check("misal_strobes", {o_DR0, o_DR1, o_DR2, o_DR3}, 0);
        check("misal_ready", PREADY, 1);
        check("misal_data", o_PRDATA, 0);
        end_xfer();

        rf_rand = 1;
        for (int t = 0; t < 80; t++) begin
            begin_xfer(1'($urandom), rand_addr(), 8'($urandom), 8'($urandom));
            end_xfer();
            repeat ($urandom_range(0, 2)) step();
        end
        rf_rand = 0;
        rfin  = 1'b0;
        sh_en = 1'b0;

        do_reset();
        send_bits(72);
        @(negedge clk);
        check("sync_pending", pkt_rec, 0);
        check("sync_sr_low", dut.u_sync.sr[7:0], 8'hFF);
        step();
        @(negedge clk);
        check("sync_set", pkt_rec, 1);
        check("sync_sr_clr", dut.u_sync.sr, 0);
        begin_xfer(0, 16'h0040, 8'h00, 8'h81);
        end_xfer();
        @(negedge clk);
        check("sync_status_clr", pkt_rec, 0);

        do_reset();
        send_bits(71);
        repeat (3) step();
        @(negedge clk);
        check("sync_71_bits", pkt_rec, 0);

        step();
        i_PSEL0  = 1'b1;
        i_PWRITE = 1'b1;
        i_PADDR  = 16'h0040;
        i_PWDATA = 8'h99;
        step();
        i_PENABLE = 1'b1;
        i_PRESET  = 1'b1;
        @(negedge clk);
        check("rst_abort_wr", {o_WR0, o_WR1, o_WR2, o_WR3}, 0);
        check("rst_abort_ready", PREADY, 0);
        step();
        i_PRESET  = 1'b0;
        i_PSEL0   = 1'b0;
        i_PENABLE = 1'b0;

        send_bits(30);
        i_PRESET = 1'b1;
        step();
        i_PRESET = 1'b0;
        @(negedge clk);
        check("rst_sync_pkt", pkt_rec, 0);
        check("rst_sync_sr", dut.u_sync.sr, 0);

        step();
        chk_on = 0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/apb_spi_bridge.md
Name: apb_spi_bridge

Overview:
- APB slave front-end for the SPI master block.
- Decodes one 8-bit APB slave window into four register write strobes (o_WR0..3) and four read strobes (o_DR0..3).
- Forwards write data to the register file and returns read data from it.
- Contains an RF sync-word detector: samples `rfin` pulses on each `sh_en` tick into a 64-bit shift register and flags `pkt_rec` when the sync mask is present.

Parameters:
- SYNC_W, 64, width of the RF sample shift register.
- SYNC_MASK, 64'h3E00_000F_8000_00FF, bits that must all be 1 for a sync match; bit 0 holds the newest sample.

Ports:
- i_PCLK  in  1  APB clock; the only clock.
- i_PRESET  in  1  reset; one clock; reset is synchronous and active-high.
- i_PSEL0  in  1  APB select.
- i_PENABLE  in  1  APB enable (access phase).
- i_PWRITE  in  1  1 = write, 0 = read.
- i_PADDR  in  16  byte address.
- i_PWDATA  in  8  APB write data.
- i_PRDATA  in  8  read data from the SPI register file.
- i_BASE_ADDR  in  10  compared with i_PADDR[15:6].
- o_WR0..o_WR3  out  1 each  write strobes: CONFIG, TX, reg2, CMD.
- o_DR0..o_DR3  out  1 each  read strobes: STATUS, RX, reg2, reg3.
- PREADY  out  1  APB ready.
- o_PWDATA  out  8  write data to the register file.
- o_PRDATA  out  8  read data to the APB master.
- rfin  in  1  RF pulse input; a 1 pulse marks a 1 bit.
- sh_en  in  1  one-cycle bit-period tick.
- pkt_rec  out  1  sync word received (sticky).

Behaviour:
- hit = (i_PADDR[15:6] == i_BASE_ADDR) && (i_PADDR[1:0] == 0).
- idx = i_PADDR[5:2]. idx 0→reg0 (offset 0x00), 1→reg1 (0x04), 2→reg2 (0x08), 3→reg3 (0x0C).
- idx ≥ 4: no strobe, read data 0.
- access = i_PSEL0 & i_PENABLE & ~i_PRESET.
- o_WRn = access & i_PWRITE & hit & (idx == n). Combinational, high for the single access-phase cycle.
- o_DRn = access & ~i_PWRITE & hit & (idx == n).
- PREADY = access, independent of hit. Zero wait states; a missed or invalid address still completes so the bus never hangs.
- o_PWDATA = i_PWDATA while access & i_PWRITE, else 0.
- o_PRDATA = i_PRDATA while any o_DRn is high, else 0.
- Setup phase (PSEL=1, PENABLE=0): no strobes, PREADY = 0.
- Sync detector, all registered on i_PCLK:
  - lat <= 1 when rfin = 1. On sh_en: sr <= {sr[SYNC_W-2:0], lat | rfin} and lat <= 0 (rfin coincident with sh_en counts as a 1).
  - match = ((sr & SYNC_MASK) == SYNC_MASK). Evaluated every cycle on the registered sr.
  - On match: pkt_rec <= 1 and sr <= 0 in the cycle after the shift that completed the pattern. Clearing sr on match has priority over a coincident sh_en; that sample is dropped.
  - pkt_rec clears on o_DR0 (STATUS read). Set wins over a simultaneous clear.
- Reset (i_PRESET = 1 at a clock edge): sr = 0, lat = 0, pkt_rec = 0. All combinational outputs are forced to 0 while i_PRESET = 1. Reset mid-transfer aborts the transfer with no strobe.

Decomposition:
- Shared package apb_spi_pkg:
  - Register offset constants: CONFIG/STATUS 0x00, TX/RX 0x04, REG2 0x08, CMD 0x0C.
  - Sync mask default.
  - Config field layout {2'b00, MODE[1:0], SLAVE[1:0], SCK[1:0]}.
  - SCK codes 00 = PCLK/2, 01 = /4, 10 = /8, 11 = /16.
- One sub-module: apb_sync_detect (lat, sr, match, pkt_rec). The APB decode stays in the top.

Test Plan:
- Base 0x001. Write PADDR 0x0040, data 0x01, two-cycle APB transfer → o_WR0 = 1 for exactly the access cycle; o_PWDATA = 0x01; PREADY = 1 in that cycle only; all other strobes 0.
- Write 0x0044 = 0x55, then 0x004C = 0x02 → o_WR1 pulses with o_PWDATA = 0x55, then o_WR3 pulses with 0x02.
- Read 0x0044 with i_PRDATA = 0xA5 → o_DR1 = 1 and o_PRDATA = 0xA5 in the access cycle. Read 0x0040 → o_DR0. o_PRDATA = 0 outside reads.
- Write 0x0080 (base mismatch) and read 0x0041 (misaligned) → no strobes, PREADY = 1 in access, o_PRDATA = 0.
- Pulse rfin once per sh_en period for 72 periods: 10 zeros, 5 ones, 21 zeros, 5 ones, 23 zeros, 8 ones → pkt_rec rises one cycle after the 72nd shift and sr reads 0. A STATUS read then clears pkt_rec. A 71-bit sequence leaves pkt_rec = 0.
- Assert i_PRESET during a write access phase and during a partial sync sequence → no o_WR strobe; pkt_rec = 0 and sr = 0 afterwards.
